// File: rtl/iter_div.sv
// Radix-2 restoring integer divider: one quotient bit per cycle, signed or unsigned,
// valid/ready on request and result, with flush-driven cancel.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             div_cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   rem;
    logic [WIDTH-1:0]     ay;
    logic [WIDTH-1:0]     ax;
    logic [WIDTH:0]       trial;
    logic                 sign_q, sign_r, y_zero;
    logic                 accept, last;

    assign div_ready = (state == IDLE) && !div_cancel;
    assign accept    = div_valid && div_ready;
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(WIDTH));
    assign ax        = (div_signed && x[WIDTH-1]) ? -x : x;
    // rem_hi can reach 2|y|-1 after the shift, so the trial needs one extra bit
    assign trial     = rem[2*WIDTH-1:WIDTH-1] - {1'b0, ay};

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (div_cancel) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)    state_nxt = CALC;
                CALC:    if (last)      state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default:                state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            rem    <= '0;
            ay     <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            y_zero <= 1'b0;
            s      <= '0;
            r      <= '0;
        end else if (accept) begin
            rem    <= {{WIDTH{1'b0}}, ax};
            ay     <= (div_signed && y[WIDTH-1]) ? -y : y;
            sign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            sign_r <= div_signed & x[WIDTH-1];
            y_zero <= (y == '0);
            cnt    <= '0;
        end else if (state == CALC && !div_cancel) begin
            if (!last) begin
                // quotient bits enter at the bottom; remainder lives in the top half
                if (!trial[WIDTH]) rem <= {trial[WIDTH-1:0], rem[WIDTH-2:0], 1'b1};
                else               rem <= {rem[2*WIDTH-2:0], 1'b0};
                cnt <= cnt + 1'b1;
            end else begin
                // y==0 leaves |x| as remainder, so only the quotient needs forcing
                s <= y_zero ? '1 : (sign_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]);
                r <= sign_r ? -rem[2*WIDTH-1:WIDTH] : rem[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: literal expectations per vector plus a queue-based
// arithmetic model checked on every cycle a result is presented.
module tb_iter_div;
    localparam int W = 32;

    logic         div_clk = 0, resetn = 0;
    logic         div_valid = 0, div_signed = 0, div_cancel = 0, out_ready = 1;
    logic [W-1:0] x = '0, y = '0;
    logic         div_ready, out_valid;
    logic [W-1:0] s, r;

    int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
    bit prev_ov = 0;

    typedef struct packed { logic [W-1:0] s; logic [W-1:0] r; } res_t;
    res_t expq[$];

    iter_div #(.WIDTH(W)) dut (
        .div_clk(div_clk), .resetn(resetn), .div_valid(div_valid), .div_ready(div_ready),
        .div_signed(div_signed), .x(x), .y(y), .div_cancel(div_cancel),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .r(r)
    );

    always #5 div_clk = ~div_clk;
    always @(posedge div_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        res_t o;
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            o.s = '1; o.r = a;
        end else if (sg && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            o.s = a; o.r = '0;
        end else if (sg) begin
            o.s = sa / sb; o.r = sa % sb;
        end else begin
            o.s = a / b; o.r = a % b;
        end
        return o;
    endfunction

    // Scoreboard: decisions read at negedge, where inputs and outputs are settled
    always @(negedge div_clk) begin
        if (!resetn) begin
            expq.delete();
            prev_ov = 0;
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_out_valid", W'(out_valid), '0);
                end else begin
                    check("model_s", s, expq[0].s);
                    check("model_r", r, expq[0].r);
                    check("busy_not_ready", W'(div_ready), '0);
                    if (!prev_ov) check("latency", W'(cyc - acc_cyc), W'(W + 1));
                end
            end
            prev_ov = out_valid;
            if (div_cancel) expq.delete();
            else if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
            if (div_valid && div_ready) begin
                expq.push_back(model(x, y, div_signed));
                acc_cyc = cyc + 1;
            end
        end
    end

    task automatic issue(input logic [W-1:0] xx, input logic [W-1:0] yy, input logic sg);
        @(posedge div_clk); #1;
        x = xx; y = yy; div_signed = sg; div_valid = 1;
        @(posedge div_clk); #1;
        div_valid = 0;
        x = $urandom; y = $urandom; div_signed = ~sg;
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge div_clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) check("timeout_out_valid", '0, W'(1));
    endtask

    task automatic run(input string nm, input logic [W-1:0] xx, input logic [W-1:0] yy,
                       input logic sg, input logic [W-1:0] es, input logic [W-1:0] er);
        bit ok;
        issue(xx, yy, sg);
        wait_out(ok);
        if (ok) begin
            check({nm, "_s"}, s, es);
            check({nm, "_r"}, r, er);
            @(posedge div_clk); #1;
            @(negedge div_clk);
            check({nm, "_ready_after"}, W'(div_ready), W'(1));
            check({nm, "_ov_after"}, W'(out_valid), '0);
        end
    endtask

    task automatic watch_quiet(input string nm, input int n);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge div_clk);
            if (out_valid) seen = 1;
        end
        check(nm, W'(seen), '0);
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge div_clk);
        #1;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_s", s, '0);
        check("rst_r", r, '0);
        resetn = 1;
        @(negedge div_clk);
        check("rst_ready", W'(div_ready), W'(1));

        run("u100_7",  32'd100,      32'd7,        1'b0, 32'd14,       32'd2);
        run("s_m7_2",  32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run("s_7_m2",  32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1);
        run("u_max_1", 32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0);
        run("dz_u",    32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678);
        run("dz_s",    32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678);
        run("dz_s_neg",32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9);
        run("ovf",     32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0);
        run("u_big",   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000);

        // Backpressure: result must hold while the consumer stalls
        out_ready = 0;
        issue(32'd1000, 32'd3, 1'b0);
        wait_out(ok);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                check("bp_valid", W'(out_valid), W'(1));
                check("bp_s", s, 32'd333);
                check("bp_r", r, 32'd1);
                check("bp_ready", W'(div_ready), '0);
                @(negedge div_clk);
            end
            @(posedge div_clk); #1;
            out_ready = 1;
            @(negedge div_clk);
            check("bp_valid_last", W'(out_valid), W'(1));
            @(posedge div_clk); #1;
            @(negedge div_clk);
            check("bp_released_valid", W'(out_valid), '0);
            check("bp_released_ready", W'(div_ready), W'(1));
            watch_quiet("bp_single_handshake", 5);
        end

        // Cancel at CALC iteration 10
        issue(32'd12345, 32'd6, 1'b0);
        repeat (9) @(posedge div_clk);
        #1 div_cancel = 1;
        @(posedge div_clk); #1;
        div_cancel = 0;
        @(negedge div_clk);
        check("cancel_ready", W'(div_ready), W'(1));
        check("cancel_ov", W'(out_valid), '0);
        watch_quiet("cancel_no_result", 45);
        run("after_cancel", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);

        // Cancel and request in the same IDLE cycle: no accept
        @(posedge div_clk); #1;
        x = 32'd5; y = 32'd1; div_signed = 0; div_valid = 1; div_cancel = 1;
        @(negedge div_clk);
        check("cancel_valid_ready", W'(div_ready), '0);
        @(posedge div_clk); #1;
        div_valid = 0; div_cancel = 0;
        @(negedge div_clk);
        check("cancel_valid_idle", W'(div_ready), W'(1));
        watch_quiet("cancel_valid_no_result", 40);

        // Asynchronous reset between edges in the middle of CALC
        issue(32'd77, 32'd4, 1'b0);
        repeat (5) @(posedge div_clk);
        #3 resetn = 0;
        #1;
        check("areset_ov", W'(out_valid), '0);
        check("areset_s", s, '0);
        check("areset_r", r, '0);
        @(negedge div_clk);
        @(posedge div_clk); #1;
        resetn = 1;
        @(negedge div_clk);
        check("areset_ready", W'(div_ready), W'(1));
        check("areset_ov_after", W'(out_valid), '0);
        run("after_reset", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Multi-cycle radix-2 restoring integer divider for the CPU execute stage; the division counterpart to the single-cycle-registered Wallace multiplier.
- Takes a 32-bit dividend and divisor, signed or unsigned, and returns quotient and remainder (div.w/mod.w/div.wu/mod.wu) through valid/ready handshakes on both input and output.
- Supports cancellation when the pipeline flushes.

Parameters:
- WIDTH, 32, operand and result width; must be even and ≥ 4. Iteration counter is clog2(WIDTH)+1 bits.

Ports:
- div_clk     input   1      clock; all state updates on rising edge
- resetn      input   1      reset, asynchronous, active-low
- div_valid   input   1      request valid
- div_ready   output  1      divider can accept a request
- div_signed  input   1      1 = two's-complement operands, 0 = unsigned
- x           input   WIDTH  dividend
- y           input   WIDTH  divisor
- div_cancel  input   1      abort current operation (pipeline flush)
- out_valid   output  1      result valid
- out_ready   input   1      consumer accepts result
- s           output  WIDTH  quotient
- r           output  WIDTH  remainder

Behaviour:
- Clock and reset: one clock, div_clk. Reset is asynchronous and active-low on resetn.
- Reset: resetn low forces the following immediately, regardless of clock, including mid-operation:
  - state = IDLE, out_valid = 0, s = 0, r = 0, counter = 0.
  - div_ready = 1 once resetn is high.
- States:
  - IDLE: div_ready = (state==IDLE) && !div_cancel. Accept occurs on div_valid && div_ready. On accept, latch the following, then go to CALC:
    - |x| and |y| (absolute values when div_signed, else raw);
    - sign_q = div_signed & (x[MSB] ^ y[MSB]);
    - sign_r = div_signed & x[MSB];
    - y==0 flag;
    - counter = 0.
  - CALC: one quotient bit per cycle, MSB first, on a (2*WIDTH)-bit shifting remainder.
    - Each step: trial = rem_hi − |y| (WIDTH+1 bits).
    - If trial ≥ 0: quotient bit = 1 and rem_hi = trial. Otherwise quotient bit = 0 and the remainder is restored.
    - After WIDTH cycles, go to DONE.
  - DONE: out_valid = 1. s and r are registered and stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE on the next edge.
- Latency:
  - Accept at edge T.
  - CALC occupies edges T+1 .. T+WIDTH.
  - out_valid is high from the cycle after edge T+WIDTH+1, i.e. WIDTH+1 cycles after accept (33 for WIDTH=32).
- No overlap: no new request is accepted until the result is consumed or cancelled. div_ready = 0 in CALC and DONE.
- Sign correction, applied when entering DONE:
  - s = sign_q ? −q : q.
  - r = sign_r ? −rem : rem.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (y==0): s = all ones and r = x (original dividend), for both signed and unsigned. Full latency still applies.
- Signed overflow (x = 0x80000000, y = −1): s = 0x80000000, r = 0. Natural wrap, no flag.
- Cancel:
  - div_cancel high in any state: next edge → IDLE, out_valid = 0, result discarded.
  - Cancel takes priority over accept and over out_ready in the same cycle.
  - s and r keep their last values; they are don't-care while out_valid = 0.
- Input stability: x, y, div_signed are sampled only at accept. Later changes have no effect.
- WIDTH arithmetic: negation uses WIDTH-bit two's complement. |0x80000000| = 0x80000000 is treated as unsigned magnitude.

Test Plan:
- Unsigned 100 / 7, div_signed=0, out_ready=1 → out_valid rises exactly 33 cycles after accept; s=14, r=2; div_ready=1 the cycle after the output handshake.
- Signed −7/2 and 7/−2 back-to-back:
  - −7/2 → s=0xFFFFFFFD, r=0xFFFFFFFF.
  - 7/−2 → s=0xFFFFFFFD, r=1.
  - 0xFFFFFFFF/1 unsigned → s=0xFFFFFFFF, r=0.
- Corner operands:
  - x=0x12345678, y=0, both signednesses → s=0xFFFFFFFF, r=0x12345678.
  - Signed 0x80000000 / 0xFFFFFFFF → s=0x80000000, r=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, s, r unchanged and div_ready=0 throughout. out_ready=1 → single handshake, then IDLE.
- Cancel:
  - Assert div_cancel at CALC iteration 10 → out_valid never rises; div_ready=1 next cycle. A new 50/5 request then yields s=10, r=0.
  - Cancel in the same cycle as div_valid in IDLE → no accept.
- Async reset: drive resetn low mid-CALC between clock edges → out_valid=0, s=0, r=0 immediately. After release, div_ready=1 and a fresh 9/3 request gives s=3, r=0.
